lsu_rmw: RTL
============

Name: lsu_rmw

Overview:
Load/store unit that initiates data-side accesses to the word-wide `mem` block on behalf of the RV32I core. It accepts one byte-addressed load or store request at a time. Loads are resolved to LB/LH/LW/LBU/LHU with sign or zero extension. SB/SH stores become read-modify-write sequences because `mem` exposes only a whole-word write enable. It sits between the core's execute stage and the `mem` data port (addr / writeData / we / readData).

Parameters:
- ADDR_W, 16, width of the `mem` word address; byte address bits used = ADDR_W+2.
- XLEN, 32, data width; fixed at 32 for RV32I.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  request strobe; sampled only when ready=1.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I funct3 of the load/store.
- byte_addr  in  XLEN  byte address; bits above ADDR_W+1 are ignored.
- store_data  in  XLEN  store operand (rs2).
- ready  out  1  unit idle; a request is accepted this cycle if req=1.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misaligned address or illegal funct3.
- load_data  out  XLEN  extended load result; valid from done, held until the next load completes.
- mem_we  out  1  write enable to `mem`.
- mem_addr  out  ADDR_W  word address = latched byte_addr[ADDR_W+1:2].
- mem_wdata  out  XLEN  write data to `mem`.
- mem_rdata  in  XLEN  combinational read data from `mem` at mem_addr.

Behaviour:
- States: IDLE, LD, RMW_RD, WR, DONE. State is held in a register cleared by rst.
- Reset values: state=IDLE, ready=1, done=0, err=0, load_data=0, mem_we=0, mem_addr=0, mem_wdata=0. All latched request fields are cleared to 0.
- Accept: in IDLE with req=1, latch req_we, funct3, byte_addr and store_data at the clock edge. The FSM then moves to:
  - DONE with err=1 if the request is misaligned or illegal (see below).
  - otherwise LD for a load, WR for SW, RMW_RD for SB/SH.
- LD: mem_addr is driven from the latched address. At the end of the cycle, load_data <= extend(mem_rdata). Next state DONE.
- RMW_RD: at the end of the cycle, the merge register <= mem_rdata with the addressed lane replaced by store_data.
  - SB replaces byte lane addr[1:0] with store_data[7:0].
  - SH replaces half addr[1] with store_data[15:0].
  - Next state WR.
- WR: mem_we=1 for exactly this cycle, so the memory write occurs at the closing edge.
  - mem_wdata = store_data for SW, merge register for SB/SH.
  - Next state DONE.
- DONE: done=1 for one cycle, and err is valid in this cycle. Next state IDLE.
- ready=1 only in IDLE. A req outside IDLE is ignored, not queued.
- mem_we is decoded combinationally from state and is asserted only in WR.
- Latency from accept edge to done high: load 2 cycles, SW 2 cycles, SB/SH 3 cycles, error 1 cycle.
- Byte order is little-endian. Load extraction:
  - LB: byte at addr[1:0], sign-extended. LBU: same byte, zero-extended.
  - LH: half at addr[1], sign-extended. LHU: same half, zero-extended.
  - LW: whole word.
- Error conditions:
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Illegal funct3: loads 011/110/111; stores other than 000/001/010.
  - On error there is no memory access, mem_we stays 0, and load_data is unchanged.
- Address wrap: word address 2^ADDR_W-1 is legal; there is no wrap inside a single access because all accesses are aligned.
- Reset mid-operation: state returns to IDLE immediately and mem_we drops asynchronously.
  - A WR interrupted before its edge does not write.
  - A pending done is lost.

Decomposition:
- Shared package rv_mem_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - the LSU state encoding.
- One combinational sub-module, lsu_align, performs:
  - load lane extraction and sign/zero extension;
  - store lane merge.
- lsu_rmw holds the FSM and registers.

Test Plan:
- Reset: rst=1 asserted during WR of an SW -> mem_we=0 immediately; after release ready=1, load_data=0, memory word unchanged.
- SW byte_addr=0x8, data=0xDEADBEEF -> mem_addr=2, mem_we high 1 cycle, done 2 cycles after accept. Then LW 0x8 -> load_data=0xDEADBEEF, err=0.
- SB 0x9, data=0x55 over 0xDEADBEEF -> RMW_RD then WR with mem_wdata=0xDEAD55EF. Then:
  - LB 0x9 -> 0x00000055.
  - LB 0xB -> 0xFFFFFFDE.
  - LBU 0xB -> 0x000000DE.
- SH 0xA, data=0x1234 over 0xDEAD55EF -> word 0x123455EF. Then:
  - LHU 0xA -> 0x00001234.
  - LH 0x8 -> 0x000055EF.
  - After SH 0x8 data 0xBEEF, LH 0x8 -> 0xFFFFBEEF.
- LW 0x6 -> done with err=1 one cycle after accept, no mem_we, load_data unchanged. SH 0x5 and funct3=011 load -> err=1, no write.
- req held high continuously through an SB -> ready=0 and req ignored in RMW_RD/WR/DONE; the next request is accepted only in the IDLE cycle after DONE.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared load/store constants, LSU state encoding and request legality check.
package rv_mem_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // LSU state encoding
    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] S_LD     = 3'd1;
    localparam logic [ST_W-1:0] S_RMW_RD = 3'd2;
    localparam logic [ST_W-1:0] S_WR     = 3'd3;
    localparam logic [ST_W-1:0] S_DONE   = 3'd4;

    // 1 when the request is misaligned or uses an illegal funct3
    function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
        logic bad;
        bad = 1'b1;
        if (we) begin
            case (f3)
                F3_B:    bad = 1'b0;
                F3_H:    bad = lo[0];
                F3_W:    bad = |lo;
                default: bad = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: bad = 1'b0;
                F3_H, F3_HU: bad = lo[0];
                F3_W:        bad = |lo;
                default:     bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction / extension for loads and lane merge for sub-word stores.
module lsu_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane (little-endian) and extend it
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_ext = {24'd0, byte_sel};
            F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_ext = {16'd0, half_sel};
            default: load_ext = rdata;
        endcase
    end

    // Replace the addressed lane of the current word with the store operand
    always_comb begin
        store_merged = rdata;
        case (funct3)
            F3_B:    store_merged[{addr_lo, 3'b000} +: 8]   = wdata[7:0];
            F3_H:    store_merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit for a word-only memory; sub-word stores become read-modify-write.
module lsu_rmw
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   byte_addr,
    input  logic [XLEN-1:0]   store_data,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   load_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned BA_W = ADDR_W + 2;

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic [2:0]      f3_q;
    logic [BA_W-1:0] addr_q;
    logic [XLEN-1:0] sdata_q;
    logic [XLEN-1:0] merge_q;
    logic            err_q;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] store_merged;
    logic            req_err;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^byte_addr[XLEN-1:BA_W];
    assign req_err        = req_bad(req_we, funct3, byte_addr[1:0]);

    lsu_align u_align (
        .funct3       (f3_q),
        .addr_lo      (addr_q[1:0]),
        .rdata        (mem_rdata),
        .wdata        (sdata_q),
        .load_ext     (load_ext),
        .store_merged (store_merged)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (req_err)             state_nxt = S_DONE;
                    else if (!req_we)        state_nxt = S_LD;
                    else if (funct3 == F3_W) state_nxt = S_WR;
                    else                     state_nxt = S_RMW_RD;
                end
            end
            S_LD:     state_nxt = S_DONE;
            S_RMW_RD: state_nxt = S_WR;
            S_WR:     state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request latch, load result and merge register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q      <= 3'd0;
            addr_q    <= '0;
            sdata_q   <= '0;
            merge_q   <= '0;
            err_q     <= 1'b0;
            load_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        f3_q    <= funct3;
                        addr_q  <= byte_addr[BA_W-1:0];
                        sdata_q <= store_data;
                        // SW writes the operand directly; SB/SH overwrite this in RMW_RD
                        merge_q <= store_data;
                        err_q   <= req_err;
                    end
                end
                S_LD:     load_data <= load_ext;
                S_RMW_RD: merge_q   <= store_merged;
                default:  ;
            endcase
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        ready     = (state == S_IDLE);
        done      = (state == S_DONE);
        err       = (state == S_DONE) && err_q;
        mem_we    = (state == S_WR);
        mem_addr  = addr_q[BA_W-1:2];
        mem_wdata = merge_q;
    end

endmodule
